// File: rtl/gerador_pulsos_pkg.sv
// Shared definitions for the gerador_pulsos burst generator: state encoding and
// default field widths.
package gerador_pulsos_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        PULSO     = 2'd1,
        INTERVALO = 2'd2,
        FIM       = 2'd3
    } estado_t;

endpackage

// File: rtl/gerador_pulsos_contador_intervalo.sv
// Loadable down-counter that times the idle gap between pulses; zero flags
// the last gap cycle.
module contador_intervalo
    import gerador_pulsos_pkg::*;
#(
    parameter int unsigned GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             carga,
    input  logic             dec,
    input  logic [GAP_W-1:0] valor,
    output logic             zero
);

    logic [GAP_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (carga) begin
            cnt <= valor;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gerador_pulsos.sv
// Burst generator driving the ent input of the pulse-counting FSM.
// Optional Y_MODEL_EN adds y_esp, the predicted counting-FSM output.
module gerador_pulsos
    import gerador_pulsos_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] n,
    input  logic [GAP_W-1:0] intervalo,
    output logic             pronto,
    output logic             ent,
    output logic             fim,
    output logic [WIDTH-1:0] conta
`ifdef Y_MODEL_EN
    ,
    output logic             y_esp
`endif
);

    estado_t          estado;
    logic [WIDTH-1:0] restante;
    logic [GAP_W-1:0] gap;
    logic [WIDTH-1:0] conta_inc;
    logic             ultimo;
    logic             gap_carga;
    logic             gap_dec;
    logic             gap_zero;

    assign conta_inc = conta + 1'b1;
    assign ultimo    = (restante == WIDTH'(1));

    // The counter is loaded with gap-1 so its zero flag marks the final idle cycle.
    assign gap_carga = (estado == PULSO) && !ultimo && (gap != '0);
    assign gap_dec   = (estado == INTERVALO);

    contador_intervalo #(
        .GAP_W(GAP_W)
    ) u_contador_intervalo (
        .clk  (clk),
        .rst  (rst),
        .carga(gap_carga),
        .dec  (gap_dec),
        .valor(gap - 1'b1),
        .zero (gap_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= OCIOSO;
            pronto   <= 1'b1;
            ent      <= 1'b0;
            fim      <= 1'b0;
            conta    <= '0;
            restante <= '0;
            gap      <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        restante <= n;
                        gap      <= intervalo;
                        conta    <= '0;
                        pronto   <= 1'b0;
                        if (n != '0) begin
                            estado <= PULSO;
                            ent    <= 1'b1;
                        end else begin
                            estado <= FIM;
                            fim    <= 1'b1;
                        end
                    end
                end
                PULSO: begin
                    restante <= restante - 1'b1;
                    conta    <= conta_inc;
                    if (ultimo) begin
                        estado <= FIM;
                        ent    <= 1'b0;
                        fim    <= 1'b1;
                    end else if (gap != '0) begin
                        estado <= INTERVALO;
                        ent    <= 1'b0;
                    end
                end
                INTERVALO: begin
                    if (gap_zero) begin
                        estado <= PULSO;
                        ent    <= 1'b1;
                    end
                end
                FIM: begin
                    estado <= OCIOSO;
                    fim    <= 1'b0;
                    pronto <= 1'b1;
                end
                default: begin
                    estado <= OCIOSO;
                    pronto <= 1'b1;
                    ent    <= 1'b0;
                    fim    <= 1'b0;
                end
            endcase
        end
    end

`ifdef Y_MODEL_EN
    // Tracks conta as it will read after this edge, matching the counting FSM's update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_esp <= 1'b0;
        end else if ((estado == OCIOSO) && inicio) begin
            y_esp <= 1'b0;
        end else if (estado == PULSO) begin
            y_esp <= &conta_inc[1:0];
        end
    end
`endif

endmodule

// File: tb/tb_gerador_pulsos.sv
// Self-checking bench for gerador_pulsos: table vectors, hand sequences and
// randomized bursts against a closed-form timing model.
module tb_gerador_pulsos;

    localparam int W  = 8;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inicio;
    logic [W-1:0]  n;
    logic [GW-1:0] intervalo;
    logic          pronto;
    logic          ent;
    logic          fim;
    logic [W-1:0]  conta;
`ifdef Y_MODEL_EN
    logic          y_esp;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gerador_pulsos #(
        .WIDTH(W),
        .GAP_W(GW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inicio   (inicio),
        .n        (n),
        .intervalo(intervalo),
        .pronto   (pronto),
        .ent      (ent),
        .fim      (fim),
        .conta    (conta)
`ifdef Y_MODEL_EN
        ,
        .y_esp    (y_esp)
`endif
    );

    typedef struct {
        int n;
        int g;
        int pulses;
        int fim_cycle;
        int conta;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pronto();
        int w;
        w = 0;
        while (pronto !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check("pronto_before_start", pronto, 1);
    endtask

    // Expected waveform from the closed-form rules: pulse i in cycle 1+(i-1)(G+1),
    // fim in cycle N+(N-1)G+1, conta counts pulses in earlier cycles.
    task automatic run_burst(input int bn, input int bg, input int noise);
        int   fc;
        int   exp_conta;
        logic exp_ent;
        inicio = 1'b0;
        wait_pronto();
        n         = W'(bn);
        intervalo = GW'(bg);
        inicio    = 1'b1;
        step();
        fc = (bn == 0) ? 1 : bn + (bn - 1) * bg + 1;
        for (int k = 1; k <= fc + 1; k++) begin
            exp_ent   = (bn > 0) && (k < fc) && (((k - 1) % (bg + 1)) == 0);
            exp_conta = (k - 1 + bg) / (bg + 1);
            if (exp_conta > bn) exp_conta = bn;
            check("burst_ent", ent, exp_ent);
            check("burst_fim", fim, k == fc);
            check("burst_pronto", pronto, k > fc);
            check("burst_conta", conta, exp_conta);
`ifdef Y_MODEL_EN
            check("burst_y_esp", y_esp, (exp_conta % 4) == 3);
`endif
            if (k > fc) inicio = 1'b0;
            else if (noise == 1) inicio = 1'($urandom_range(0, 1));
            else if (noise == 2) inicio = 1'b1;
            else inicio = 1'b0;
            if (noise != 0) begin
                n         = W'($urandom);
                intervalo = GW'($urandom);
            end
            step();
        end
        inicio = 1'b0;
    endtask

    initial begin
        vec_t tab[6];
        int   pulses;
        int   fc;
        int   k;
        int   spacing_bad;
        int   fim_seen;

        tab[0] = '{n: 3,   g: 0,  pulses: 3,   fim_cycle: 4,    conta: 3};
        tab[1] = '{n: 4,   g: 2,  pulses: 4,   fim_cycle: 11,   conta: 4};
        tab[2] = '{n: 0,   g: 5,  pulses: 0,   fim_cycle: 1,    conta: 0};
        tab[3] = '{n: 1,   g: 0,  pulses: 1,   fim_cycle: 2,    conta: 1};
        tab[4] = '{n: 2,   g: 15, pulses: 2,   fim_cycle: 18,   conta: 2};
        tab[5] = '{n: 255, g: 15, pulses: 255, fim_cycle: 4066, conta: 255};

        rst       = 1'b1;
        inicio    = 1'b0;
        n         = '0;
        intervalo = '0;
        #1;
        check("reset_pronto", pronto, 1);
        check("reset_ent", ent, 0);
        check("reset_fim", fim, 0);
        check("reset_conta", conta, 0);
`ifdef Y_MODEL_EN
        check("reset_y_esp", y_esp, 0);
`endif
        step();
        step();
        rst = 1'b0;
        step();

        for (int r = 0; r < 6; r++) begin
            wait_pronto();
            n         = W'(tab[r].n);
            intervalo = GW'(tab[r].g);
            inicio    = 1'b1;
            step();
            inicio      = 1'b0;
            k           = 1;
            pulses      = 0;
            fc          = 0;
            spacing_bad = 0;
            while (fc == 0 && k < 5000) begin
                if (ent === 1'b1) begin
                    pulses++;
                    if (((k - 1) % (tab[r].g + 1)) != 0) spacing_bad++;
                end
                if (fim === 1'b1) begin
                    fc = k;
                end else begin
                    step();
                    k++;
                end
            end
            check("tab_pulses", pulses, tab[r].pulses);
            check("tab_fim_cycle", fc, tab[r].fim_cycle);
            check("tab_conta", conta, tab[r].conta);
            check("tab_spacing", spacing_bad, 0);
            step();
            check("tab_pronto_after_fim", pronto, 1);
        end

        // inicio held high through PULSO and FIM must not disturb the burst
        run_burst(3, 0, 2);
        run_burst(4, 2, 2);

        // reset during the second gap of n=5, intervalo=3
        wait_pronto();
        n         = W'(5);
        intervalo = GW'(3);
        inicio    = 1'b1;
        step();
        inicio = 1'b0;
        repeat (6) step();
        check("pre_rst_ent", ent, 0);
        check("pre_rst_conta", conta, 2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_ent", ent, 0);
        check("rst_fim", fim, 0);
        check("rst_pronto", pronto, 1);
        check("rst_conta", conta, 0);
        step();
        rst      = 1'b0;
        fim_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (fim === 1'b1 || ent === 1'b1) fim_seen++;
            step();
        end
        check("rst_no_fim_no_ent", fim_seen, 0);
        run_burst(1, 0, 0);

        for (int r = 0; r < 25; r++) begin
            run_burst(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
